aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one AES core (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32, maximum core busy cycles before abort.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  N_REQ  per-requester block pending.
REQ-006 SHALL have port req_data_i  input  N_REQ*128  per-requester block; slice i is bits [128*i+127:128*i].
REQ-007 SHALL have port req_ready_o  input-acknowledge output  N_REQ  one-hot accept pulse.
REQ-008 SHALL have port core_start_o  output  1  single-cycle start pulse to the AES core.
REQ-009 SHALL have port core_data_o  output  128  block presented to the core; held stable from start until finish.
REQ-010 SHALL have port core_finish_i  input  1  core completion pulse.
REQ-011 SHALL have port core_data_i  input  128  core result; valid when core_finish_i=1.
REQ-012 SHALL have port rsp_valid_o  output  1  response available.
REQ-013 SHALL have port rsp_id_o  output  2  index of the served requester.
REQ-014 SHALL have port rsp_data_o  output  128  result block.
REQ-015 SHALL have port rsp_err_o  output  1  response is a timeout abort.
REQ-016 SHALL have port rsp_ready_i  input  1  consumer accepts response.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
REQ-018 IDLE: if any req_valid_i, grant first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0); assert req_ready_o[grant] that cycle; latch data and id; go to ISSUE.
REQ-019 ISSUE: core_start_o=1 for exactly one cycle; go to BUSY; busy counter cleared.
REQ-020 BUSY: on core_finish_i, capture core_data_i into rsp_data_o, rsp_err_o=0, go to RESP; otherwise increment busy counter.
REQ-021 RESP: rsp_valid_o=1, outputs stable until rsp_ready_i=1; on handshake, rr_ptr=grant+1 modulo N_REQ, go to IDLE.
REQ-022 Minimum request-to-response latency SHALL be 3 cycles plus core latency; one block in flight at a time.
REQ-023 core_finish_i outside BUSY SHALL be ignored.
REQ-024 req_valid_i deasserted by a requester while not granted SHALL have no effect; no request is stored except the granted one.
REQ-025 rsp_valid_o=1 with rsp_ready_i=1 and new req_valid_i in the same cycle: the new grant happens in the next IDLE cycle, not earlier.

Reset
REQ-026 Reset SHALL force state IDLE, rr_ptr=0, busy counter=0, and all outputs 0 (rsp_data_o and core_data_o 128'h0).
REQ-027 Reset asserted mid-operation SHALL abandon the in-flight block without a response; the core is not re-signalled.

Configuration
REQ-028 With AES_ARB_TIMEOUT_EN defined: in BUSY, when the busy counter reaches TIMEOUT_CYC without finish, go to RESP with rsp_err_o=1 and rsp_data_o=0; finish in that same cycle takes priority (normal response).
REQ-029 Without AES_ARB_TIMEOUT_EN: BUSY waits indefinitely, busy counter not implemented, rsp_err_o tied 0.

Structure
REQ-030 State encoding, 128-bit block width constant, and default TIMEOUT_CYC SHALL live in shared package aes_pkg.
REQ-031 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req vector, rr_ptr; output one-hot grant, index).

Verification
REQ-032 Single request: req_valid_i=4'b0100, data A, core finish 12 cycles after start with B -> req_ready_o=4'b0100, one start pulse, rsp_id_o=2, rsp_data_o=B, rsp_err_o=0.
REQ-033 Fairness: req_valid_i=4'b1111 held for 4 transactions -> grants in order 0,1,2,3.
REQ-034 Backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o, rsp_id_o, rsp_data_o stable; no new req_ready_o until handshake.
REQ-035 Timeout (macro on, TIMEOUT_CYC=32): no finish -> rsp_err_o=1, rsp_data_o=0 after 32 BUSY cycles; finish on cycle 32 -> rsp_err_o=0.
REQ-036 Reset in BUSY: rst_ni low 2 cycles -> all outputs 0; next request from requester 3 with rr_ptr=0 and req_valid_i=4'b1001 grants requester 0.
REQ-037 Spurious core_finish_i in IDLE and RESP -> no state or output change.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter.
package aes_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned TIMEOUT_CYC_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_e;

    // Round-robin pointer moves one past the served requester, wrapping at n.
    function automatic logic [1:0] next_ptr(input logic [1:0] id, input int unsigned n);
        return (32'(id) + 1 == n) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or after ptr, wrapping N_REQ-1 -> 0.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       idx
);

    int unsigned pos;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = 2'(pos);
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core among N_REQ requesters, one block in flight at a time.
// Optional busy timeout abort enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*BLOCK_W-1:0] req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     core_start_o,
    output logic [BLOCK_W-1:0]       core_data_o,
    input  logic                     core_finish_i,
    input  logic [BLOCK_W-1:0]       core_data_i,
    output logic                     rsp_valid_o,
    output logic [1:0]               rsp_id_o,
    output logic [BLOCK_W-1:0]       rsp_data_o,
    output logic                     rsp_err_o,
    input  logic                     rsp_ready_i
);

    state_e           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       cur_id;
    logic [N_REQ-1:0] grant;
    logic [1:0]       grant_idx;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] busy_cnt;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Accept is the only combinational output: the grant must be visible in the IDLE cycle itself.
    assign req_ready_o = (state == IDLE) ? grant : '0;

`ifndef AES_ARB_TIMEOUT_EN
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            core_start_o <= 1'b0;
            core_data_o  <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_data_o   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_o    <= 1'b0;
            busy_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        cur_id       <= grant_idx;
                        core_data_o  <= req_data_i[grant_idx*BLOCK_W +: BLOCK_W];
                        core_start_o <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start_o <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
                    busy_cnt     <= '0;
`endif
                    state        <= BUSY;
                end
                BUSY: begin
                    if (core_finish_i) begin
                        rsp_data_o  <= core_data_i;
                        rsp_id_o    <= cur_id;
                        rsp_valid_o <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    // Counter holds completed BUSY cycles, so this is the last allowed one.
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data_o  <= '0;
                        rsp_id_o    <= cur_id;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rr_ptr      <= next_ptr(cur_id, N_REQ);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed self-checking bench for aes_core_arbiter; timeout steps need AES_ARB_TIMEOUT_EN.
module tb_aes_core_arbiter;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [511:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         core_start;
    logic [127:0] core_wdata;
    logic         core_finish = 1'b0;
    logic [127:0] core_rdata = '0;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         rsp_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    aes_core_arbiter #(.N_REQ(4), .TIMEOUT_CYC(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .core_start_o  (core_start),
        .core_data_o   (core_wdata),
        .core_finish_i (core_finish),
        .core_data_i   (core_rdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .rsp_err_o     (rsp_err),
        .rsp_ready_i   (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " start"}, 128'(core_start), '0);
        chk({tag, " core_data"}, core_wdata, '0);
        chk({tag, " rsp_valid"}, 128'(rsp_valid), '0);
        chk({tag, " rsp_id"}, 128'(rsp_id), '0);
        chk({tag, " rsp_data"}, rsp_data, '0);
        chk({tag, " rsp_err"}, 128'(rsp_err), '0);
        chk({tag, " ready"}, 128'(req_ready), '0);
    endtask

    // One full transaction: grant, start pulse, core latency lat, response held for stall cycles.
    task automatic txn(input string tag, input logic [3:0] valid, input logic hold,
                       input int exp_id, input int lat, input logic [127:0] res, input int stall);
        req_valid = valid;
        #1;
        chk({tag, " grant"}, 128'(req_ready), 128'(4'b0001 << exp_id));
        tick();
        if (!hold) req_valid = '0;
        chk({tag, " start"}, 128'(core_start), 128'(1));
        chk({tag, " core_data"}, core_wdata, blk(exp_id));
        chk({tag, " ready_issue"}, 128'(req_ready), '0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, " busy"}, 128'({core_start, rsp_valid, req_ready}), '0);
        end
        core_finish = 1'b1;
        core_rdata  = res;
        tick();
        core_finish = 1'b0;
        core_rdata  = {4{$urandom}};
        chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1));
        chk({tag, " rsp_id"}, 128'(rsp_id), 128'(exp_id));
        chk({tag, " rsp_data"}, rsp_data, res);
        chk({tag, " rsp_err"}, 128'(rsp_err), '0);
        for (int i = 0; i < stall; i++) begin
            if (i == 0) core_finish = 1'b1;
            tick();
            core_finish = 1'b0;
            chk({tag, " hold"}, {rsp_valid, rsp_err, rsp_id, rsp_data[123:0]},
                {1'b1, 1'b0, 2'(exp_id), res[123:0]});
            chk({tag, " hold_ready"}, 128'(req_ready), '0);
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, " hs_ready"}, 128'(req_ready), '0);
        tick();
        rsp_ready = 1'b0;
        chk({tag, " done"}, 128'(rsp_valid), '0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_data[i*128 +: 128] = blk(i);

        // Reset state
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fairness with all requesters pending, backpressure on the second response
        txn("fair0", 4'b1111, 1'b1, 0, 3, 128'h1111, 0);
        txn("fair1", 4'b1111, 1'b1, 1, 1, 128'h2222, 5);
        txn("fair2", 4'b1111, 1'b1, 2, 2, 128'h3333, 0);
        txn("fair3", 4'b1111, 1'b1, 3, 4, 128'h4444, 1);
        req_valid = '0;

        // Spurious finish while idle
        core_finish = 1'b1;
        core_rdata  = 128'hDEAD;
        tick();
        core_finish = 1'b0;
        chk("idle_spur valid", 128'(rsp_valid), '0);
        chk("idle_spur start", 128'(core_start), '0);
        chk("idle_spur data", rsp_data, 128'h4444);

        // Single request, core latency 12
        txn("single", 4'b0100, 1'b0, 2, 12, 128'hB0B0_B0B0_1234_5678_9ABC_DEF0_0BAD_CAFE, 0);

        // Reset while busy, then round-robin pointer restarts at 0
        req_valid = 4'b1000;
        #1;
        chk("rstbusy grant", 128'(req_ready), 128'(4'b1000));
        tick();
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("rstbusy");
        tick();
        tick();
        chk("rstbusy start", 128'(core_start), '0);
        rst_n = 1'b1;
        txn("post_rst", 4'b1001, 1'b0, 0, 2, 128'hC0C0, 0);

`ifdef AES_ARB_TIMEOUT_EN
        req_valid = 4'b0010;
        #1;
        chk("tmo grant", 128'(req_ready), 128'(4'b0010));
        tick();
        req_valid = '0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("tmo wait", 128'(rsp_valid), '0);
        end
        tick();
        chk("tmo valid", 128'(rsp_valid), 128'(1));
        chk("tmo err", 128'(rsp_err), 128'(1));
        chk("tmo data", rsp_data, '0);
        chk("tmo id", 128'(rsp_id), 128'(1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        txn("fin32", 4'b0001, 1'b0, 0, 32, 128'hD0D0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
